// File: rtl/simon_bus_master.sv
// Bus initiator that drives one SIMON-128/128 encryption per request through the register block.
// Optional key cache: define SIMON_KEY_CACHE_EN to skip rewriting an unchanged key.
module simon_bus_master #(
    parameter int unsigned POLL_DELAY = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [127:0] pt_i,
    input  logic [127:0] key_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output logic [127:0] ct_o,
    output logic         err_o,
    output logic         bus_en_o,
    output logic [3:0]   bus_we_o,
    output logic [7:0]   bus_addr_o,
    output logic [31:0]  bus_wdata_o,
    input  logic [31:0]  bus_rdata_i
);

    localparam int unsigned PCW = $clog2(TIMEOUT + 1);
    localparam int unsigned DCW = (POLL_DELAY > 0) ? $clog2(POLL_DELAY + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_PT, WR_KEY, WR_START, DELAY, POLL_RD, POLL_CHK, RD_CT, RD_LAST, RESP
    } state_t;

    state_t         state, state_d;
    logic [1:0]     idx, idx_d;
    logic [DCW-1:0] dly, dly_d;
    logic [PCW-1:0] polls, polls_d;
    logic [127:0]   pt_q, pt_d, key_q, key_d, ct_q, ct_d;
    logic           err_q, err_d;
    logic           bus_en_d;
    logic [3:0]     bus_we_d;
    logic [7:0]     bus_addr_d;
    logic [31:0]    bus_wdata_d;
    logic           key_hit;
    logic           timed_out;

    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
        case (i)
            2'd0:    word_of = v[127:96];
            2'd1:    word_of = v[95:64];
            2'd2:    word_of = v[63:32];
            default: word_of = v[31:0];
        endcase
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] i,
                                              input logic [31:0] w);
        put_word = v;
        case (i)
            2'd0:    put_word[127:96] = w;
            2'd1:    put_word[95:64]  = w;
            2'd2:    put_word[63:32]  = w;
            default: put_word[31:0]   = w;
        endcase
    endfunction

    assign timed_out = (polls == PCW'(TIMEOUT));

`ifdef SIMON_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic         cache_vld;
    logic         cache_upd;
    logic         cache_clr;

    assign cache_upd = (state == WR_KEY) && (idx == 2'd3);
    assign cache_clr = (state == POLL_CHK) && !bus_rdata_i[1] && timed_out;
    assign key_hit   = cache_vld && (cache_key == key_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_key <= '0;
            cache_vld <= 1'b0;
        end else if (cache_upd) begin
            cache_key <= key_q;
            cache_vld <= 1'b1;
        end else if (cache_clr) begin
            cache_vld <= 1'b0;
        end
    end
`else
    assign key_hit = 1'b0;
`endif

    always_comb begin
        state_d = state;
        idx_d   = idx;
        dly_d   = dly;
        polls_d = polls;
        pt_d    = pt_q;
        key_d   = key_q;
        ct_d    = ct_q;
        err_d   = err_q;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    pt_d    = pt_i;
                    key_d   = key_i;
                    idx_d   = '0;
                    state_d = WR_PT;
                end
            end
            WR_PT: begin
                idx_d = idx + 2'd1;
                if (idx == 2'd3) state_d = key_hit ? WR_START : WR_KEY;
            end
            WR_KEY: begin
                idx_d = idx + 2'd1;
                if (idx == 2'd3) state_d = WR_START;
            end
            WR_START: begin
                dly_d   = DCW'(POLL_DELAY);
                polls_d = '0;
                state_d = (POLL_DELAY == 0) ? POLL_RD : DELAY;
            end
            DELAY: begin
                dly_d = dly - 1'b1;
                if (dly <= DCW'(1)) state_d = POLL_RD;
            end
            POLL_RD: begin
                polls_d = polls + 1'b1;
                state_d = POLL_CHK;
            end
            POLL_CHK: begin
                if (bus_rdata_i[1]) begin
                    idx_d   = '0;
                    state_d = RD_CT;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    ct_d    = '0;
                    state_d = RESP;
                end else begin
                    state_d = POLL_RD;
                end
            end
            RD_CT: begin
                // read data trails its address by one cycle, so capture the previous word
                idx_d = idx + 2'd1;
                if (idx != 2'd0) ct_d = put_word(ct_q, idx - 2'd1, bus_rdata_i);
                if (idx == 2'd3) state_d = RD_LAST;
            end
            RD_LAST: begin
                ct_d    = put_word(ct_q, 2'd3, bus_rdata_i);
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so they are derived from the state being entered.
        bus_en_d    = 1'b0;
        bus_we_d    = '0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        case (state_d)
            WR_PT: begin
                bus_en_d    = 1'b1;
                bus_we_d    = '1;
                bus_addr_d  = {4'h0, idx_d, 2'b00};
                bus_wdata_d = word_of(pt_d, idx_d);
            end
            WR_KEY: begin
                bus_en_d    = 1'b1;
                bus_we_d    = '1;
                bus_addr_d  = {4'h1, idx_d, 2'b00};
                bus_wdata_d = word_of(key_d, idx_d);
            end
            WR_START: begin
                bus_en_d    = 1'b1;
                bus_we_d    = '1;
                bus_addr_d  = 8'h30;
                bus_wdata_d = 32'h0000_0001;
            end
            POLL_RD: begin
                bus_en_d   = 1'b1;
                bus_addr_d = 8'h30;
            end
            RD_CT: begin
                bus_en_d   = 1'b1;
                bus_addr_d = {4'h2, idx_d, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dly         <= '0;
            polls       <= '0;
            pt_q        <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            err_q       <= 1'b0;
            bus_en_o    <= 1'b0;
            bus_we_o    <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            dly         <= dly_d;
            polls       <= polls_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
            err_q       <= err_d;
            bus_en_o    <= bus_en_d;
            bus_we_o    <= bus_we_d;
            bus_addr_o  <= bus_addr_d;
            bus_wdata_o <= bus_wdata_d;
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign ct_o         = ct_q;
    assign err_o        = err_q;

endmodule
